// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_arbiter_pkg : shared encodings for the main-memory arbiter
// Revision: 1.0
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam logic [1:0] ARB_GNT_NONE = 2'd0;
  localparam logic [1:0] ARB_GNT_IC   = 2'd1;
  localparam logic [1:0] ARB_GNT_DCR  = 2'd2;
  localparam logic [1:0] ARB_GNT_DCW  = 2'd3;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_pick.sv
`default_nettype none
// ============================================================================
// arb_pick : combinational fixed-priority selector with starvation override
// Revision: 1.0
// ============================================================================
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic       ic_req,
  input  logic       dcr_req,
  input  logic       dcw_req,
  input  logic       starve,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = ARB_GNT_NONE;
    if (ic_req && starve)  gnt = ARB_GNT_IC;
    else if (dcw_req)      gnt = ARB_GNT_DCW;
    else if (dcr_req)      gnt = ARB_GNT_DCR;
    else if (ic_req)       gnt = ARB_GNT_IC;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : one-line-at-a-time arbiter of the memory port between
//               Icache read, Dcache refill and Dcache write-back
// Revision: 1.0
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic              ic_read_ack,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic              dc_read_ack,
  output logic [LINE_W-1:0] dc_read_data,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] mem_data_out,
  output logic [1:0]        grant_id
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [1:0]       w_pick;
  logic             w_starve;

  assign w_starve = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  arb_pick u_pick (
    .ic_req  (ic_read_req),
    .dcr_req (dc_read_req),
    .dcw_req (dc_write_req),
    .starve  (w_starve),
    .gnt     (w_pick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // DONE always returns to IDLE so a just-acked requester has a cycle to drop req
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (w_pick != ARB_GNT_NONE) state_nxt = ARB_BUSY;
      ARB_BUSY: if (mem_ack)                state_nxt = ARB_DONE;
      ARB_DONE:                             state_nxt = ARB_IDLE;
      default:                              state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ic_read_ack  <= 1'b0;
      dc_read_ack  <= 1'b0;
      dc_write_ack <= 1'b0;
      ic_read_data <= '0;
      dc_read_data <= '0;
      mem_enable   <= 1'b0;
      mem_rw       <= MEM_READ;
      mem_addr     <= '0;
      mem_data_out <= '0;
      grant_id     <= ARB_GNT_NONE;
    end else begin
      ic_read_ack  <= 1'b0;
      dc_read_ack  <= 1'b0;
      dc_write_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (w_pick != ARB_GNT_NONE) begin
            grant_id   <= w_pick;
            mem_enable <= 1'b1;
            mem_rw     <= (w_pick == ARB_GNT_DCW) ? MEM_WRITE : MEM_READ;
            case (w_pick)
              ARB_GNT_IC:  mem_addr <= ic_read_addr;
              ARB_GNT_DCR: mem_addr <= dc_read_addr;
              default: begin
                mem_addr     <= dc_write_addr;
                mem_data_out <= dc_write_data;
              end
            endcase
          end
        end
        ARB_BUSY: begin
          if (mem_ack) begin
            mem_enable   <= 1'b0;
            ic_read_ack  <= (grant_id == ARB_GNT_IC);
            dc_read_ack  <= (grant_id == ARB_GNT_DCR);
            dc_write_ack <= (grant_id == ARB_GNT_DCW);
            if (grant_id == ARB_GNT_IC)  ic_read_data <= mem_data_in;
            if (grant_id == ARB_GNT_DCR) dc_read_data <= mem_data_in;
          end
        end
        ARB_DONE: grant_id <= ARB_GNT_NONE;
        default: ;
      endcase
    end
  end

  // Counts Dcache wins while the Icache waits; any edge without an Icache request clears it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve_cnt <= '0;
    end else if (!ic_read_req) begin
      r_starve_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (w_pick == ARB_GNT_IC)
        r_starve_cnt <= '0;
      else if (w_pick != ARB_GNT_NONE && !w_starve)
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : randomized requesters and memory against a transaction model
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ic_read_req = 1'b0;
  logic [ADDR_W-1:0] ic_read_addr = '0;
  logic              ic_read_ack;
  logic [LINE_W-1:0] ic_read_data;
  logic              dc_read_req = 1'b0;
  logic [ADDR_W-1:0] dc_read_addr = '0;
  logic              dc_read_ack;
  logic [LINE_W-1:0] dc_read_data;
  logic              dc_write_req = 1'b0;
  logic [ADDR_W-1:0] dc_write_addr = '0;
  logic [LINE_W-1:0] dc_write_data = '0;
  logic              dc_write_ack;
  logic              mem_enable;
  logic              mem_rw;
  logic              mem_ack = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_data_in = '0;
  logic [LINE_W-1:0] mem_data_out;
  logic [1:0]        grant_id;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
    .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
    .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
    .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
    .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
    .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .grant_id(grant_id)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing store for the memory model; unwritten lines return an address pattern
  logic [127:0] mem_store [logic [31:0]];

  function automatic logic [127:0] mem_read(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111_1111, 32'hC0DE_0000 | a};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Transaction model: 0 = free for a grant, 1 = a line in flight, 2 = completion cycle just reported
  int           phase = 0;
  int           owner = 0;
  int           k = 0;
  logic [31:0]  exp_addr;
  logic         exp_rw;
  logic [127:0] exp_wdata, exp_rdata;
  logic [127:0] last_ic = '0, last_dcr = '0;
  int           mem_cnt = 0;
  bit           mem_active = 0;
  int           p_ic = 0, p_dcr = 0, p_dcw = 0, p_wd = 0;
  int           fixed_lat = 0;
  bit           force_mem_ack = 0;
  int           starve_rounds = 0, dc_run = 0;

  task automatic tick();
    int win;
    int acked;
    logic [2:0] acks, exp_acks;
    @(negedge clk);
    acked = 0;
    acks = {dc_write_ack, dc_read_ack, ic_read_ack};
    case (phase)
      0: begin
        if (ic_read_req || dc_read_req || dc_write_req) begin
          if (ic_read_req && k == STARVE_LIMIT) win = 1;
          else if (dc_write_req)                win = 3;
          else if (dc_read_req)                 win = 2;
          else                                  win = 1;
          owner    = win;
          exp_addr = (win == 1) ? ic_read_addr : (win == 2) ? dc_read_addr : dc_write_addr;
          exp_rw   = (win == 3);
          if (win == 3) exp_wdata = dc_write_data;
          check_val("grant_enable", mem_enable, 1);
          check_val("grant_id", grant_id, win);
          check_val("grant_rw", mem_rw, exp_rw);
          check_val("grant_addr", mem_addr, exp_addr);
          if (win == 3) check_val("grant_wdata", mem_data_out, exp_wdata);
          if (starve_rounds > 0) begin
            if (win == 1) begin
              check_val("starve_dc_grants", dc_run, STARVE_LIMIT);
              dc_run = 0;
              starve_rounds--;
            end else dc_run++;
          end
          if (win == 1) k = 0;
          else if (ic_read_req && k < STARVE_LIMIT) k++;
          mem_cnt    = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
          mem_active = 1;
          phase      = 1;
        end else begin
          check_val("idle_enable", mem_enable, 0);
          check_val("idle_grant_id", grant_id, 0);
          check_val("idle_acks", acks, 0);
        end
      end
      1: begin
        check_val("busy_grant_id", grant_id, owner);
        if (mem_ack) begin
          exp_acks = 3'b001 << (owner - 1);
          check_val("done_enable", mem_enable, 0);
          check_val("done_acks", acks, exp_acks);
          if (owner == 1) begin check_val("ic_rdata", ic_read_data, exp_rdata); last_ic = exp_rdata; end
          if (owner == 2) begin check_val("dc_rdata", dc_read_data, exp_rdata); last_dcr = exp_rdata; end
          acked = owner;
          phase = 2;
        end else begin
          check_val("busy_enable", mem_enable, 1);
          check_val("busy_rw", mem_rw, exp_rw);
          check_val("busy_addr", mem_addr, exp_addr);
          if (exp_rw) check_val("busy_wdata", mem_data_out, exp_wdata);
          check_val("busy_acks", acks, 0);
        end
      end
      default: begin
        check_val("post_enable", mem_enable, 0);
        check_val("post_grant_id", grant_id, 0);
        check_val("post_acks", acks, 0);
        phase = 0;
      end
    endcase
    if (!ic_read_req) k = 0;
    check_val("ic_data_hold", ic_read_data, last_ic);
    check_val("dc_data_hold", dc_read_data, last_dcr);

    // Requesters: drop on ack, sometimes withdraw early, sometimes raise new lines
    if (acked == 1) ic_read_req = 0;
    else if (ic_read_req && !(phase == 1 && owner == 1) && $urandom_range(0, 99) < p_wd) ic_read_req = 0;
    else if (!ic_read_req && $urandom_range(0, 99) < p_ic) begin
      ic_read_req = 1; ic_read_addr = {24'h0, 4'($urandom_range(0, 15)), 4'h0};
    end
    if (acked == 2) dc_read_req = 0;
    else if (dc_read_req && !(phase == 1 && owner == 2) && $urandom_range(0, 99) < p_wd) dc_read_req = 0;
    else if (!dc_read_req && $urandom_range(0, 99) < p_dcr) begin
      dc_read_req = 1; dc_read_addr = {24'h0, 4'($urandom_range(0, 15)), 4'h0};
    end
    if (acked == 3) dc_write_req = 0;
    else if (dc_write_req && !(phase == 1 && owner == 3) && $urandom_range(0, 99) < p_wd) dc_write_req = 0;
    else if (!dc_write_req && $urandom_range(0, 99) < p_dcw) begin
      dc_write_req = 1; dc_write_addr = {24'h0, 4'($urandom_range(0, 15)), 4'h0};
      dc_write_data = rand128();
    end
    if (phase == 1 && $urandom_range(0, 99) < 30) begin
      if (owner == 1 && ic_read_req) ic_read_addr = $urandom;
      if (owner == 2 && dc_read_req) dc_read_addr = $urandom;
      if (owner == 3 && dc_write_req) begin dc_write_addr = $urandom; dc_write_data = rand128(); end
    end

    // Memory model
    mem_ack = 0;
    mem_data_in = rand128();
    if (phase == 1 && mem_active) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_active = 0;
        if (mem_rw) mem_store[mem_addr] = mem_data_out;
        exp_rdata   = mem_read(exp_addr);
        mem_data_in = exp_rdata;
        mem_ack     = 1;
      end
    end else if (phase == 2 && $urandom_range(0, 99) < 30) begin
      mem_ack = 1;
    end else if (phase == 0 && !ic_read_req && !dc_read_req && !dc_write_req &&
                 (force_mem_ack || $urandom_range(0, 99) < 20)) begin
      mem_ack = 1;
      force_mem_ack = 0;
    end
  endtask

  task automatic drain();
    int n;
    p_ic = 0; p_dcr = 0; p_dcw = 0; p_wd = 0;
    n = 0;
    while (!(phase == 0 && !ic_read_req && !dc_read_req && !dc_write_req && !mem_ack) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check_val("drain_timeout", 1, 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_ctrl", {ic_read_ack, dc_read_ack, dc_write_ack, mem_enable, mem_rw, grant_id}, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_wdata", mem_data_out, 0);
    check_val("rst_rdata", {ic_read_data, dc_read_data}, 0);
    reset = 1;
    run(3);

    // Single Icache read, memory answers 5 cycles after mem_enable
    fixed_lat = 5;
    ic_read_req = 1; ic_read_addr = 32'h0000_0040;
    run(10);
    drain();

    // Write-back and refill together: write is served first
    fixed_lat = 3;
    dc_write_req = 1; dc_write_addr = 32'h100; dc_write_data = {4{32'hDEAD_BEEF}};
    dc_read_req = 1;  dc_read_addr = 32'h200;
    run(14);
    drain();

    // Starvation: Icache held while Dcache refills continuously
    fixed_lat = 2;
    starve_rounds = 2; dc_run = 0;
    p_ic = 100; p_dcr = 100; p_dcw = 0; p_wd = 0;
    ic_read_req = 1; ic_read_addr = 32'h30;
    dc_read_req = 1; dc_read_addr = 32'h50;
    for (int i = 0; i < 200 && starve_rounds > 0; i++) tick();
    check_val("starve_rounds_done", starve_rounds, 0);
    starve_rounds = 0;
    drain();

    // Randomized traffic
    fixed_lat = 0;
    p_ic = 30; p_dcr = 30; p_dcw = 20; p_wd = 5;
    run(3000);
    drain();

    // Asynchronous reset in the middle of a transaction
    fixed_lat = 8;
    dc_read_req = 1; dc_read_addr = 32'h70;
    run(3);
    check_val("pre_reset_busy", mem_enable, 1);
    #2 reset = 0;
    #1;
    check_val("async_rst_ctrl", {ic_read_ack, dc_read_ack, dc_write_ack, mem_enable, mem_rw, grant_id}, 0);
    check_val("async_rst_addr", mem_addr, 0);
    check_val("async_rst_rdata", {ic_read_data, dc_read_data}, 0);
    ic_read_req = 0; dc_read_req = 0; dc_write_req = 0; mem_ack = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    phase = 0; owner = 0; k = 0; mem_active = 0; last_ic = '0; last_dcr = '0;
    run(2);
    force_mem_ack = 1;
    run(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single main-memory port between three cache requesters: Icache line read, Dcache line read (refill) and Dcache line write (write-back).
- Sits directly downstream of the Icache/Dcache miss interfaces and directly upstream of the synchronous memory model.
- Serves one full-line transaction at a time using a req/ack handshake on both sides.
- Fixed priority with an Icache anti-starvation counter.

Parameters:
- ADDR_W, 32, address width (equals REG_SIZE)
- LINE_W, 128, cache line / memory data width (equals WIDTH)
- STARVE_LIMIT, 4, consecutive Dcache grants tolerated while ic_read_req is pending

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ic_read_req  in  1  Icache line read request; level, held until ack
- ic_read_addr  in  ADDR_W  Icache line address
- ic_read_ack  out  1  one-cycle pulse; ic_read_data valid this cycle
- ic_read_data  out  LINE_W  returned line
- dc_read_req  in  1  Dcache refill request
- dc_read_addr  in  ADDR_W  Dcache refill address
- dc_read_ack  out  1  one-cycle pulse; dc_read_data valid this cycle
- dc_read_data  out  LINE_W  returned line
- dc_write_req  in  1  Dcache write-back request
- dc_write_addr  in  ADDR_W  write-back address
- dc_write_data  in  LINE_W  write-back line
- dc_write_ack  out  1  one-cycle pulse; write completed
- mem_enable  out  1  memory transaction active; held until mem_ack
- mem_rw  out  1  1 = write, 0 = read
- mem_ack  in  1  memory completion pulse
- mem_addr  out  ADDR_W  memory address
- mem_data_in  in  LINE_W  read data from memory, valid with mem_ack
- mem_data_out  out  LINE_W  write data to memory
- grant_id  out  2  current owner: 0 = none, 1 = IC read, 2 = DC read, 3 = DC write (debug/hazard use)

Behaviour:
- Reset (reset == 0, asynchronous):
  - FSM goes to IDLE.
  - All outputs go to 0: acks, mem_enable, mem_rw, mem_addr, mem_data_out, both read-data outputs, grant_id.
  - Starvation counter clears.
  - An in-flight memory transaction is abandoned; a mem_ack arriving after reset release is ignored.
- All outputs are registered; there are no combinational req-to-output paths.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req is high at the clock edge, pick the winner, latch its address (and dc_write_data for writes) into mem_addr/mem_data_out, set mem_rw, mem_enable = 1 and grant_id, then go to BUSY.
  - mem_enable therefore rises 1 cycle after req is first seen.
- Priority:
  - Default order is dc_write > dc_read > ic_read. A write-back precedes its refill.
  - If ic_read_req is pending and the counter equals STARVE_LIMIT, the Icache wins regardless of Dcache requests.
  - The counter increments on each Dcache grant while ic_read_req is high.
  - The counter clears on an Icache grant, or on any edge with ic_read_req low.
  - The counter saturates at STARVE_LIMIT.
- BUSY:
  - mem_enable, mem_rw, mem_addr and mem_data_out are held stable.
  - Requester inputs are ignored. Address and data were latched at grant, so requester changes have no effect.
  - On mem_ack == 1:
    - for reads, capture mem_data_in into the owner's read-data register;
    - drop mem_enable;
    - go to DONE.
- DONE:
  - The owner's ack is high for exactly one cycle. Read data is valid in the same cycle and holds until that requester's next ack.
  - grant_id returns to 0 on exit.
  - The next state is always IDLE, giving the requester one cycle to drop req so it is never served twice.
- Latency: req seen → ack = memory latency (mem_enable to mem_ack) + 2 cycles minimum.
- mem_ack while in IDLE or DONE: ignored, with no state change.
- Simultaneous requests: exactly one grant per IDLE→BUSY transition. Losers keep req high and are served in later rounds.
- Requests dropped before grant: never served, no ack.
- mem_rw and mem_addr are never changed while mem_enable is high.

Decomposition:
- Add to define.v:
  - state encodings ARB_IDLE, ARB_BUSY, ARB_DONE;
  - grant encodings ARB_GNT_NONE, ARB_GNT_IC, ARB_GNT_DCR, ARB_GNT_DCW;
  - MEM_READ = 0 and MEM_WRITE = 1.
- One natural sub-module, arb_pick: a combinational priority and starvation selector.
  - Inputs: the three reqs and a starve flag.
  - Output: a 2-bit grant code.
  - Reused later for the L2 port.

Test Plan:
- Single IC read: ic_read_req = 1, addr 0x00000040; memory acks 5 cycles after mem_enable. Expect mem_enable 1 cycle after req, mem_rw = 0, mem_addr = 0x40. ic_read_ack pulses 1 cycle after mem_ack with ic_read_data = the 128-bit pattern returned. grant_id goes 1 → 0.
- Simultaneous dc_write (0x100, data 0xDEAD...) and dc_read (0x200). Expect write served first (mem_rw = 1, mem_data_out = 0xDEAD...), dc_write_ack, IDLE for 1 cycle, then read of 0x200 and dc_read_ack.
- Starvation: ic_read_req held high while Dcache issues continuous reads. Expect exactly 4 Dcache grants, then an IC grant, then the counter cleared.
- Requester changes dc_write_addr/data during BUSY. Expect mem_addr/mem_data_out unchanged until mem_ack.
- Async reset (reset = 0) asserted mid-BUSY. Expect all outputs 0 immediately without a clock edge. A mem_ack 2 cycles after release produces no ack, and the FSM stays in IDLE.
- Spurious mem_ack in IDLE with no req. Expect no ack, no state change and mem_enable stays 0.
